// File: rtl/mem_stage.sv
// MEM pipeline stage: captures the EX->MEM bus, drives a valid/addr_ok/data_ok
// data SRAM port, aligns load data and stalls on WB back-pressure.
module mem_stage #(
  parameter int BUS_IN_W  = 108,
  parameter int BUS_OUT_W = 70
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ex2mem_valid_i,
  input  logic [BUS_IN_W-1:0]  ex2mem_bus_i,
  output logic                 mem_allowin_o,
  output logic                 mem2wb_valid_o,
  input  logic                 wb_allowin_i,
  output logic [BUS_OUT_W-1:0] mem2wb_bus_o,
  output logic                 data_req_o,
  output logic                 data_wr_o,
  output logic [1:0]           data_size_o,
  output logic [31:0]          data_addr_o,
  output logic [3:0]           data_wstrb_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_addr_ok_i,
  input  logic                 data_data_ok_i,
  input  logic [31:0]          data_rdata_i,
  output logic                 mem_ale_o
);

  // Field positions inside the EX->MEM bus (LSB offsets).
  localparam int PC_LSB  = 0;
  localparam int WE_BIT  = 32;
  localparam int RD_LSB  = 33;
  localparam int EX_LSB  = 38;
  localparam int ST_LSB  = 70;
  localparam int CTL_LSB = 102;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic [1:0] size;
    logic       uns;
  } mem_op_t;

  // Load and store both set decodes as neither; ctl[0] is reserved.
  function automatic mem_op_t decode_op(input logic [5:1] ctl);
    mem_op_t op;
    op.ld   = ctl[5] & ~ctl[4];
    op.st   = ctl[4] & ~ctl[5];
    op.size = ctl[3:2];
    op.uns  = ctl[1];
    return op;
  endfunction

  // Size 2'b11 is handled as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   return {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic                  ale_q, ale_d;
  logic [BUS_IN_W-1:0]   bus_q, bus_d;
  logic [31:0]           rdata_q, rdata_d;

  mem_op_t               in_op;
  logic                  in_mem, in_mis;
  logic                  accept;
  state_e                in_next;

  mem_op_t               q_op;
  logic [31:0]           q_addr, q_st, q_pc, wb_data;
  logic [4:0]            q_rd;
  logic                  q_mis, wb_rd_we;
  logic                  unused_ctl_rsvd;

  // Decode of the incoming instruction only steers the next state; it never
  // reaches an output without passing through a flop.
  assign in_op  = decode_op(ex2mem_bus_i[CTL_LSB+1 +: 5]);
  assign in_mem = in_op.ld | in_op.st;
  assign in_mis = in_mem & misaligned(in_op.size, ex2mem_bus_i[EX_LSB +: 2]);

  assign mem_allowin_o = (state_q == S_IDLE) | ((state_q == S_DONE) & wb_allowin_i);
  assign accept        = ex2mem_valid_i & mem_allowin_o;
  assign in_next       = (in_mem & ~in_mis) ? S_REQ : S_DONE;

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    bus_d   = bus_q;
    rdata_d = rdata_q;
    ale_d   = accept & in_mis;

    if (accept) bus_d = ex2mem_bus_i;

    case (state_q)
      S_IDLE: if (accept) state_d = in_next;
      S_REQ: begin
        if (data_addr_ok_i) begin
          if (data_data_ok_i) begin
            state_d = S_DONE;
            rdata_d = data_rdata_i;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_data_ok_i) begin
          state_d = S_DONE;
          rdata_d = data_rdata_i;
        end
      end
      S_DONE: if (wb_allowin_i) state_d = accept ? in_next : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_DONE);
  end

  // Reset also abandons any outstanding SRAM response; it is not tracked afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ale_q   <= 1'b0;
      bus_q   <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ale_q   <= ale_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
    end
  end

  assign q_op   = decode_op(bus_q[CTL_LSB+1 +: 5]);
  assign q_addr = bus_q[EX_LSB +: 32];
  assign q_st   = bus_q[ST_LSB +: 32];
  assign q_rd   = bus_q[RD_LSB +: 5];
  assign q_pc   = bus_q[PC_LSB +: 32];
  assign q_mis  = (q_op.ld | q_op.st) & misaligned(q_op.size, q_addr[1:0]);
  assign unused_ctl_rsvd = bus_q[CTL_LSB];

  assign data_req_o   = req_q;
  assign data_wr_o    = q_op.st;
  assign data_size_o  = q_op.size;
  assign data_addr_o  = q_addr;

  always_comb begin
    data_wstrb_o = 4'b1111;
    data_wdata_o = q_st;
    case (q_op.size)
      2'b00: begin
        data_wstrb_o = 4'b0001 << q_addr[1:0];
        data_wdata_o = {4{q_st[7:0]}};
      end
      2'b01: begin
        data_wstrb_o = 4'b0011 << q_addr[1:0];
        data_wdata_o = {2{q_st[15:0]}};
      end
      default: ;
    endcase
  end

  // Stores and faulting accesses never write the register file.
  assign wb_rd_we = bus_q[WE_BIT] & ~q_op.st & ~q_mis;
  assign wb_data  = (q_op.ld & ~q_mis) ? load_align(rdata_q, q_addr[1:0], q_op.size, q_op.uns)
                                       : q_addr;

  assign mem2wb_valid_o = valid_q;
  assign mem2wb_bus_o   = {q_rd, wb_rd_we, wb_data, q_pc};
  assign mem_ale_o      = ale_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// transactions compared against a behavioural model of the stage.
module tb_mem_stage;

  localparam int BIW = 108;
  localparam int BOW = 70;

  logic           clk;
  logic           rstn;
  logic           ex2mem_valid_i;
  logic [BIW-1:0] ex2mem_bus_i;
  logic           mem_allowin_o;
  logic           mem2wb_valid_o;
  logic           wb_allowin_i;
  logic [BOW-1:0] mem2wb_bus_o;
  logic           data_req_o;
  logic           data_wr_o;
  logic [1:0]     data_size_o;
  logic [31:0]    data_addr_o;
  logic [3:0]     data_wstrb_o;
  logic [31:0]    data_wdata_o;
  logic           data_addr_ok_i;
  logic           data_data_ok_i;
  logic [31:0]    data_rdata_i;
  logic           mem_ale_o;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.BUS_IN_W(BIW), .BUS_OUT_W(BOW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ex2mem_valid_i (ex2mem_valid_i),
    .ex2mem_bus_i   (ex2mem_bus_i),
    .mem_allowin_o  (mem_allowin_o),
    .mem2wb_valid_o (mem2wb_valid_o),
    .wb_allowin_i   (wb_allowin_i),
    .mem2wb_bus_o   (mem2wb_bus_o),
    .data_req_o     (data_req_o),
    .data_wr_o      (data_wr_o),
    .data_size_o    (data_size_o),
    .data_addr_o    (data_addr_o),
    .data_wstrb_o   (data_wstrb_o),
    .data_wdata_o   (data_wdata_o),
    .data_addr_ok_i (data_addr_ok_i),
    .data_data_ok_i (data_data_ok_i),
    .data_rdata_i   (data_rdata_i),
    .mem_ale_o      (mem_ale_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BIW-1:0] rand_bus();
    logic [127:0] g;
    g = {$urandom(), $urandom(), $urandom(), $urandom()};
    return g[BIW-1:0];
  endfunction

  // Load result: shift down by the byte offset, keep the access width, then sign-extend.
  function automatic logic [31:0] load_model(input logic [31:0] rdata, input int off,
                                             input int sz, input bit uns);
    longint v;
    v = longint'(rdata) >> (8 * off);
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rdata);
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] wstrb_model(input int off, input int sz);
    int s;
    s = (sz == 0) ? (1 << off) : (sz == 1) ? (3 << off) : 15;
    return 4'(s);
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] st, input int sz);
    longint v;
    if (sz == 0)      v = (longint'(st) % 256) * 64'h0101_0101;
    else if (sz == 1) v = (longint'(st) % 65536) * 64'h0001_0001;
    else              v = longint'(st);
    return 32'(v);
  endfunction

  // One instruction through the stage: accept, optional SRAM handshake with the
  // given latencies, then `stall` cycles of WB back-pressure before release.
  task automatic run_txn(input logic [5:0] ctl, input logic [31:0] st, input logic [31:0] exr,
                         input logic [4:0] rd, input logic we, input logic [31:0] pc,
                         input logic [31:0] rdata, input int alat, input int dlat,
                         input int stall);
    int          off, sz;
    bit          is_ld, is_st, is_mem, mis, uns;
    logic        exp_we;
    logic [31:0] exp_wb;
    logic [69:0] exp_bus, mask;

    off    = int'(exr[1:0]);
    sz     = int'(ctl[3:2]);
    is_ld  = ctl[5] && !ctl[4];
    is_st  = ctl[4] && !ctl[5];
    is_mem = is_ld || is_st;
    uns    = ctl[1];
    mis    = is_mem && ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0));
    exp_we = we && !is_st && !mis;
    exp_wb = (is_ld && !mis) ? load_model(rdata, off, sz, uns) : exr;
    exp_bus = {rd, exp_we, exp_wb, pc};
    mask    = (is_ld && mis) ? {6'h3F, 32'h0, 32'hFFFF_FFFF} : '1;

    ex2mem_valid_i = 1'b1;
    ex2mem_bus_i   = {ctl, st, exr, rd, we, pc};
    wb_allowin_i   = 1'b1;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    #1;
    check("allowin_at_accept", 128'(mem_allowin_o), 128'(1'b1));
    @(negedge clk);
    ex2mem_valid_i = 1'b0;
    ex2mem_bus_i   = rand_bus();
    wb_allowin_i   = 1'($urandom_range(0, 1));
    check("ale_after_accept", 128'(mem_ale_o), 128'(mis));

    if (is_mem && !mis) begin
      for (int i = 0; i <= alat; i++) begin
        check("req_high", 128'(data_req_o), 128'(1'b1));
        check("allowin_req", 128'(mem_allowin_o), 128'(1'b0));
        check("addr", 128'(data_addr_o), 128'(exr));
        check("size", 128'(data_size_o), 128'(ctl[3:2]));
        check("wr", 128'(data_wr_o), 128'(is_st));
        if (is_st) begin
          check("wstrb", 128'(data_wstrb_o), 128'(wstrb_model(off, sz)));
          check("wdata", 128'(data_wdata_o), 128'(wdata_model(st, sz)));
        end
        if (i == alat) begin
          data_addr_ok_i = 1'b1;
          data_data_ok_i = (dlat == 0);
          data_rdata_i   = (dlat == 0) ? rdata : $urandom();
        end else begin
          data_rdata_i = $urandom();
        end
        @(negedge clk);
      end
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b0;
      for (int i = 1; i <= dlat; i++) begin
        check("req_low_wait", 128'(data_req_o), 128'(1'b0));
        check("allowin_wait", 128'(mem_allowin_o), 128'(1'b0));
        data_data_ok_i = (i == dlat);
        data_rdata_i   = (i == dlat) ? rdata : $urandom();
        @(negedge clk);
        data_data_ok_i = 1'b0;
      end
      check("ale_quiet", 128'(mem_ale_o), 128'(1'b0));
    end

    check("valid_done", 128'(mem2wb_valid_o), 128'(1'b1));
    check("req_done", 128'(data_req_o), 128'(1'b0));
    check("bus_done", 128'(mem2wb_bus_o & mask), 128'(exp_bus & mask));

    // Stray data_ok pulses while in DONE must not disturb the held result.
    for (int i = 0; i < stall; i++) begin
      wb_allowin_i   = 1'b0;
      data_data_ok_i = 1'($urandom_range(0, 1));
      data_rdata_i   = $urandom();
      @(negedge clk);
      check("valid_hold", 128'(mem2wb_valid_o), 128'(1'b1));
      check("bus_hold", 128'(mem2wb_bus_o & mask), 128'(exp_bus & mask));
      check("allowin_hold", 128'(mem_allowin_o), 128'(1'b0));
      check("ale_hold", 128'(mem_ale_o), 128'(1'b0));
    end
    data_data_ok_i = 1'b0;
    wb_allowin_i   = 1'b1;
  endtask

  initial begin
    logic [5:0]  ctl;
    int          kind;

    rstn           = 1'b1;
    ex2mem_valid_i = 1'b0;
    ex2mem_bus_i   = '0;
    wb_allowin_i   = 1'b1;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = '0;

    // Reset state.
    #2 rstn = 1'b0;
    #1;
    check("rst_valid", 128'(mem2wb_valid_o), 128'(1'b0));
    check("rst_req", 128'(data_req_o), 128'(1'b0));
    check("rst_ale", 128'(mem_ale_o), 128'(1'b0));
    check("rst_bus", 128'(mem2wb_bus_o), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_allowin", 128'(mem_allowin_o), 128'(1'b1));
    @(negedge clk);

    // ALU op passes ex_result through one cycle after accept.
    run_txn(6'b000000, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 32'h0000_1000, 32'h0, 0, 0, 0);
    // Signed byte load from the top lane, addr_ok after 2 cycles, data_ok one later.
    run_txn(6'b100000, 32'h0, 32'h0000_0103, 5'd9, 1'b1, 32'h0000_1004, 32'h80FF_0000, 2, 1, 0);
    // Half store at an odd halfword: upper lanes, replicated data, no writeback.
    run_txn(6'b010100, 32'h0000_ABCD, 32'h0000_0202, 5'd3, 1'b1, 32'h0000_1008, 32'h0, 1, 0, 0);
    // Misaligned word load: alignment fault, no request.
    run_txn(6'b101000, 32'h0, 32'h0000_0101, 5'd4, 1'b1, 32'h0000_100C, 32'h0, 0, 0, 0);
    // WB stall for 3 cycles, then back-to-back accept of the next instruction.
    run_txn(6'b100110, 32'h0, 32'h0000_0012, 5'd6, 1'b1, 32'h0000_1010, 32'hDEAD_8765, 0, 0, 3);
    run_txn(6'b000000, 32'h0, 32'hCAFE_F00D, 5'd7, 1'b1, 32'h0000_1014, 32'h0, 0, 0, 0);

    // Reset during WAIT; the late response must be ignored.
    ex2mem_valid_i = 1'b1;
    ex2mem_bus_i   = {6'b101000, 32'h0, 32'h0000_0100, 5'd8, 1'b1, 32'h0000_1018};
    wb_allowin_i   = 1'b1;
    #1;
    check("w_allowin", 128'(mem_allowin_o), 128'(1'b1));
    @(negedge clk);
    ex2mem_valid_i = 1'b0;
    ex2mem_bus_i   = rand_bus();
    check("w_req", 128'(data_req_o), 128'(1'b1));
    data_addr_ok_i = 1'b1;
    @(negedge clk);
    data_addr_ok_i = 1'b0;
    check("w_in_wait", 128'(data_req_o), 128'(1'b0));
    rstn = 1'b0;
    #1;
    check("w_rst_valid", 128'(mem2wb_valid_o), 128'(1'b0));
    check("w_rst_req", 128'(data_req_o), 128'(1'b0));
    check("w_rst_allowin", 128'(mem_allowin_o), 128'(1'b1));
    check("w_rst_bus", 128'(mem2wb_bus_o), 128'(0));
    @(negedge clk);
    rstn           = 1'b1;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h5555_AAAA;
    @(negedge clk);
    data_data_ok_i = 1'b0;
    check("w_late_valid", 128'(mem2wb_valid_o), 128'(1'b0));
    check("w_late_bus", 128'(mem2wb_bus_o), 128'(0));
    check("w_late_allowin", 128'(mem_allowin_o), 128'(1'b1));

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      ctl  = 6'($urandom_range(0, 63));
      ctl[3:2] = 2'($urandom_range(0, 2));
      case (kind)
        0:       ctl[5:4] = 2'b00;
        1:       ctl[5:4] = 2'b11;
        2, 3:    ctl[5:4] = 2'b10;
        default: ctl[5:4] = 2'b01;
      endcase
      run_txn(ctl, $urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

    @(negedge clk);
    check("drain_valid", 128'(mem2wb_valid_o), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter BUS_IN_W, default 108, SHALL be the width of the EX->MEM bus {mem_ctl[5:0], st_data[31:0], ex_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}, MSB first.
REQ-002 Parameter BUS_OUT_W, default 70, SHALL be the width of the MEM->WB bus {rd_addr[4:0], rd_we, wb_data[31:0], pc[31:0]}, MSB first.
REQ-003 Ports, in order:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- ex2mem_valid_i  in  1  EX holds a valid instruction.
- ex2mem_bus_i  in  BUS_IN_W  EX->MEM bus.
- mem_allowin_o  out  1  MEM accepts this cycle.
- mem2wb_valid_o  out  1  MEM result valid.
- wb_allowin_i  in  1  WB accepts this cycle.
- mem2wb_bus_o  out  BUS_OUT_W  MEM->WB bus.
- data_req_o  out  1  data SRAM request.
- data_wr_o  out  1  1 = store.
- data_size_o  out  2  00 byte, 01 half, 10 word.
- data_addr_o  out  32  byte address.
- data_wstrb_o  out  4  byte enables.
- data_wdata_o  out  32  store data.
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  response complete.
- data_rdata_i  in  32  load data, word-aligned lane.
- mem_ale_o  out  1  one-cycle misaligned-access pulse.
REQ-004 mem_ctl encoding SHALL be: [5] load, [4] store, [3:2] size, [1] unsigned load, [0] reserved (ignored); load and store both set is treated as neither.

Function
REQ-005 On accept (ex2mem_valid_i & mem_allowin_o), the block SHALL register the entire input bus in one cycle; no combinational path from ex2mem_bus_i to any output.
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-007 Accept with aligned load/store -> REQ; accept with non-memory op or misaligned access -> DONE; no accept -> IDLE.
REQ-008 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; no SRAM request, mem_ale_o=1 for the cycle after accept, output rd_we forced 0.
REQ-009 REQ: data_req_o=1 with stable addr/size/wr/wstrb/wdata until data_addr_ok_i; addr_ok -> WAIT, or DONE if data_data_ok_i also high in that cycle.
REQ-010 WAIT: data_req_o=0; data_data_ok_i -> DONE, capturing data_rdata_i the same cycle.
REQ-011 DONE: mem2wb_valid_o=1; if wb_allowin_i -> REQ/DONE/IDLE for a simultaneously accepted instruction per REQ-007, else hold all outputs.
REQ-012 mem_allowin_o SHALL equal (state==IDLE) | (state==DONE & wb_allowin_i); deasserted in REQ and WAIT.
REQ-013 Latency: non-memory op valid at output 1 cycle after accept; memory op minimum 2 cycles when addr_ok and data_ok coincide with the first REQ cycle.
REQ-014 Store: wstrb byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111; wdata = byte replicated x4, half x2, word as-is; store rd_we forced 0.
REQ-015 Load: data shifted right by 8*addr[1:0], truncated to size, sign-extended unless unsigned; word loads unmodified.
REQ-016 wb_data SHALL be the load result for loads, else ex_result; rd_addr and pc pass through.
REQ-017 A data_data_ok_i outside WAIT/REQ SHALL be ignored.

Reset
REQ-018 rstn low SHALL asynchronously force state IDLE, mem2wb_valid_o=0, data_req_o=0, mem_ale_o=0, mem_allowin_o=1 after release, registered bus all-zero, including mid-transaction; the abandoned SRAM response is not tracked.

Verification
REQ-019 ALU op, ex_result=0x1234_5678, rd=5, wb_allowin=1 -> next cycle valid, wb_data=0x1234_5678, rd_we=1.
REQ-020 Signed byte load addr 0x103, rdata=0x80FF_0000, addr_ok after 2 cycles, data_ok 1 cycle later -> wb_data=0xFFFF_FF80; allowin=0 during REQ/WAIT.
REQ-021 Half store addr 0x202, st_data=0x0000_ABCD -> wstrb=1100, wdata=0xABCD_ABCD, rd_we=0.
REQ-022 Word load addr 0x101 -> no data_req_o, mem_ale_o pulse, valid with rd_we=0.
REQ-023 DONE with wb_allowin=0 for 3 cycles -> outputs stable; on allowin=1 back-to-back accept of next instruction same cycle.
REQ-024 rstn low during WAIT -> immediate IDLE, valid=0, req=0; a later data_ok produces no output.
